// File: rtl/stream_demux_pkg.sv
// Shared definitions for the stream demultiplexer.
//   demux_state_e : packet-tracking FSM encoding
//   sel_width()   : select width for a channel count, never below 1
package demux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no packet open, s_sel picks the target
    ST_FWD  = 2'd1,  // packet locked to lock_ch
    ST_DROP = 2'd2   // packet with an out-of-range select, being discarded
  } demux_state_e;

  function automatic int sel_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/stream_demux_if.sv
// Handshake bundle between one upstream stream and N_CH downstream channels.
//   s_valid/s_ready/s_data/s_last/s_sel : upstream beat
//   m_valid/m_ready/m_data/m_last       : per-channel outputs, channel i data at [i*DW +: DW]
// master = the side sourcing beats and sinking channels; slave = the demux.
interface stream_demux_if #(
  parameter int N_CH = 8,
  parameter int DW   = 8
) ();
  localparam int SEL_W = demux_pkg::sel_width(N_CH);

  logic                 s_valid;
  logic                 s_ready;
  logic [DW-1:0]        s_data;
  logic                 s_last;
  logic [SEL_W-1:0]     s_sel;
  logic [N_CH-1:0]      m_valid;
  logic [N_CH-1:0]      m_ready;
  logic [N_CH*DW-1:0]   m_data;
  logic [N_CH-1:0]      m_last;

  modport master (
    output s_valid, s_data, s_last, s_sel, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data, s_last, s_sel, m_ready,
    output s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/stream_demux_out_reg.sv
// Single-channel output register (valid/data/last).
//   load    : accept a new beat (only asserted when the slot is free or being taken)
//   take    : downstream ready
//   in_*    : beat to load
//   valid/data/last : registered channel outputs; data/last are 0 whenever valid is 0
module demux_out_reg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          take,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic          last
);
  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic          last_q, last_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load) begin
      // take-and-load in one cycle simply replaces the contents
      valid_d = 1'b1;
      data_d  = in_data;
      last_d  = in_last;
    end else if (valid_q && take) begin
      valid_d = 1'b0;
      data_d  = '0;
      last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign last  = last_q;
endmodule

// File: rtl/stream_demux.sv
// Packet-aware 1:N_CH stream demultiplexer.
//   clk, rst_n : clock, async active-low reset
//   bus        : stream_demux_if slave (upstream beat in, per-channel beats out)
//   err_sel    : pulses in the cycle a packet with an out-of-range select is accepted
//   drop_cnt   : saturating count of dropped packets
// The first beat's s_sel locks the destination for the rest of the packet.
// Each channel has a single output register, so a beat lands one cycle after
// acceptance and m_valid never depends combinationally on m_ready.
module stream_demux import demux_pkg::*; #(
  parameter int N_CH = 8,
  parameter int DW   = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  stream_demux_if.slave bus,
  output logic          err_sel,
  output logic [7:0]    drop_cnt
);
  localparam int SEL_W = sel_width(N_CH);
  localparam logic [SEL_W:0] N_CH_V = (SEL_W+1)'(N_CH);

  demux_state_e     state_q, state_d;
  logic [SEL_W-1:0] lock_ch_q, lock_ch_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  logic [SEL_W-1:0]   tgt;
  logic               tgt_ok;
  logic               tgt_free;
  logic               accept;
  logic [N_CH-1:0]    ch_free;
  logic [N_CH-1:0]    load;
  logic [N_CH-1:0]    out_v;
  logic [N_CH-1:0]    out_l;
  logic [N_CH*DW-1:0] out_d;

  // Target selection and upstream ready
  always_comb begin
    ch_free  = ~out_v | bus.m_ready;
    tgt      = (state_q == ST_FWD) ? lock_ch_q : bus.s_sel;
    // DROP and out-of-range first beats always accept so the packet drains
    tgt_ok   = (state_q == ST_FWD) ||
               ((state_q == ST_IDLE) && ({1'b0, bus.s_sel} < N_CH_V));
    tgt_free = 1'b1;
    for (int i = 0; i < N_CH; i++)
      if (tgt == SEL_W'(i)) tgt_free = ch_free[i];
    bus.s_ready = rst_n & (~tgt_ok | tgt_free);
    accept      = bus.s_valid & bus.s_ready;
    for (int i = 0; i < N_CH; i++)
      load[i] = accept & tgt_ok & (tgt == SEL_W'(i));
  end

  // Packet FSM
  always_comb begin
    state_d    = state_q;
    lock_ch_d  = lock_ch_q;
    drop_cnt_d = drop_cnt_q;
    err_sel    = 1'b0;
    if (accept) begin
      if ((state_q == ST_IDLE) && !tgt_ok) begin
        err_sel = 1'b1;
        if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
      end
      if (bus.s_last) begin
        state_d = ST_IDLE;
      end else if (state_q == ST_IDLE) begin
        if (tgt_ok) begin
          state_d   = ST_FWD;
          lock_ch_d = bus.s_sel;
        end else begin
          state_d = ST_DROP;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      lock_ch_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_ch_q  <= lock_ch_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    demux_out_reg #(.DW(DW)) u_reg (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load[i]),
      .take    (bus.m_ready[i]),
      .in_data (bus.s_data),
      .in_last (bus.s_last),
      .valid   (out_v[i]),
      .data    (out_d[i*DW +: DW]),
      .last    (out_l[i])
    );
  end

  assign bus.m_valid = out_v;
  assign bus.m_data  = out_d;
  assign bus.m_last  = out_l;
  assign drop_cnt    = drop_cnt_q;
endmodule

// File: tb/tb_stream_demux.sv
// Two demux instances (8 and 6 channels) fed identical stimulus; each is
// compared every cycle against a packet-level reference model.
module tb_stream_demux;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       tb_valid, tb_last;
  logic [7:0] tb_data;
  logic [2:0] tb_sel;
  logic [7:0] tb_rdy;

  stream_demux_if #(.N_CH(8), .DW(8)) if8 ();
  stream_demux_if #(.N_CH(6), .DW(8)) if6 ();
  logic       err8, err6;
  logic [7:0] dcnt8, dcnt6;

  assign if8.s_valid = tb_valid;  assign if6.s_valid = tb_valid;
  assign if8.s_data  = tb_data;   assign if6.s_data  = tb_data;
  assign if8.s_last  = tb_last;   assign if6.s_last  = tb_last;
  assign if8.s_sel   = tb_sel;    assign if6.s_sel   = tb_sel;
  assign if8.m_ready = tb_rdy;    assign if6.m_ready = tb_rdy[5:0];

  stream_demux #(.N_CH(8), .DW(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .bus(if8.slave), .err_sel(err8), .drop_cnt(dcnt8));
  stream_demux #(.N_CH(6), .DW(8)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .bus(if6.slave), .err_sel(err6), .drop_cnt(dcnt6));

  // observed outputs, index 0 = 8-channel, 1 = 6-channel
  logic        obs_rdy [2];
  logic        obs_err [2];
  logic [7:0]  obs_v   [2];
  logic [7:0]  obs_l   [2];
  logic [63:0] obs_d   [2];
  logic [7:0]  obs_cnt [2];
  assign obs_rdy[0] = if8.s_ready;  assign obs_rdy[1] = if6.s_ready;
  assign obs_err[0] = err8;         assign obs_err[1] = err6;
  assign obs_v[0]   = if8.m_valid;  assign obs_v[1]   = {2'b0, if6.m_valid};
  assign obs_l[0]   = if8.m_last;   assign obs_l[1]   = {2'b0, if6.m_last};
  assign obs_d[0]   = if8.m_data;   assign obs_d[1]   = {16'h0, if6.m_data};
  assign obs_cnt[0] = dcnt8;        assign obs_cnt[1] = dcnt6;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: per-channel held beat plus packet routing state
  bit         mv [2][8];
  logic [7:0] md [2][8];
  bit         ml [2][8];
  bit         pkt_open [2];
  int         pkt_dest [2];
  int         dc [2];

  function automatic int nch(input int d);
    return (d == 0) ? 8 : 6;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 8; c++) begin
        mv[d][c] = 1'b0; md[d][c] = 8'h0; ml[d][c] = 1'b0;
      end
      pkt_open[d] = 1'b0; pkt_dest[d] = 0; dc[d] = 0;
    end
  endtask

  function automatic int dest_of(input int d);
    return pkt_open[d] ? pkt_dest[d] : int'(tb_sel);
  endfunction

  function automatic bit exp_ready(input int d);
    int t;
    if (!rst_n) return 1'b0;
    t = dest_of(d);
    if (t >= nch(d)) return 1'b1;
    return !mv[d][t] || tb_rdy[t];
  endfunction

  function automatic bit exp_err(input int d);
    return rst_n && tb_valid && !pkt_open[d] && (int'(tb_sel) >= nch(d));
  endfunction

  task automatic check_all(input string pfx);
    logic [63:0] ed;
    logic [7:0]  ev, el;
    int n;
    for (int d = 0; d < 2; d++) begin
      n = nch(d);
      ed = '0; ev = '0; el = '0;
      for (int c = 0; c < n; c++) begin
        ev[c] = mv[d][c]; el[c] = ml[d][c]; ed[c*8 +: 8] = md[d][c];
      end
      chk($sformatf("%s_rdy_n%0d", pfx, n),  64'(obs_rdy[d]), 64'(exp_ready(d)));
      chk($sformatf("%s_err_n%0d", pfx, n),  64'(obs_err[d]), 64'(exp_err(d)));
      chk($sformatf("%s_mv_n%0d", pfx, n),   64'(obs_v[d]),   64'(ev));
      chk($sformatf("%s_ml_n%0d", pfx, n),   64'(obs_l[d]),   64'(el));
      chk($sformatf("%s_md_n%0d", pfx, n),   obs_d[d],        ed);
      chk($sformatf("%s_cnt_n%0d", pfx, n),  64'(obs_cnt[d]), 64'(dc[d]));
    end
  endtask

  task automatic model_clock(input int d, input bit rdy);
    bit acc;
    int t;
    acc = tb_valid && rdy;
    t = dest_of(d);
    for (int c = 0; c < nch(d); c++) begin
      if (acc && t == c) begin
        mv[d][c] = 1'b1; md[d][c] = tb_data; ml[d][c] = tb_last;
      end else if (mv[d][c] && tb_rdy[c]) begin
        mv[d][c] = 1'b0; md[d][c] = 8'h0; ml[d][c] = 1'b0;
      end
    end
    if (acc) begin
      if (!pkt_open[d] && int'(tb_sel) >= nch(d) && dc[d] < 255) dc[d]++;
      if (tb_last) pkt_open[d] = 1'b0;
      else if (!pkt_open[d]) begin
        pkt_open[d] = 1'b1;
        pkt_dest[d] = int'(tb_sel);
      end
    end
  endtask

  // One cycle: called and returns at a negedge
  task automatic step(input bit v, input logic [7:0] dat, input bit lst,
                      input logic [2:0] sel, input logic [7:0] rdy);
    bit er [2];
    tb_valid = v; tb_data = dat; tb_last = lst; tb_sel = sel; tb_rdy = rdy;
    #1;
    check_all("cyc");
    for (int d = 0; d < 2; d++) er[d] = exp_ready(d);
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_clock(d, er[d]);
    @(negedge clk);
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    model_reset();
    #1 check_all("rst_now");
    @(negedge clk);
    check_all("rst_hold");
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    tb_valid = 0; tb_data = 0; tb_last = 0; tb_sel = 0; tb_rdy = 8'hFF;
    model_reset();
    @(negedge clk);
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // single beat to ch3
    step(1, 8'hA5, 1, 3'd3, 8'hFF);
    chk("single_mv", 64'(obs_v[0]), 64'h08);
    chk("single_ml", 64'(obs_l[0]), 64'h08);
    chk("single_md", obs_d[0], 64'h0000_0000_A500_0000);
    step(0, 8'h00, 0, 3'd0, 8'hFF);

    // packet locked to ch5 despite s_sel changing
    step(1, 8'h10, 0, 3'd5, 8'hFF);
    step(1, 8'h11, 0, 3'd2, 8'hFF);
    step(1, 8'h12, 0, 3'd2, 8'hFF);
    step(1, 8'h13, 1, 3'd2, 8'hFF);
    chk("lock_mv", 64'(obs_v[0]), 64'h20);
    chk("lock_ml", 64'(obs_l[0]), 64'h20);
    chk("lock_md", obs_d[0], 64'h0000_1300_0000_0000);
    step(0, 8'h00, 0, 3'd0, 8'hFF);

    // backpressure on ch1
    step(1, 8'h21, 0, 3'd1, 8'hFD);
    step(1, 8'h22, 1, 3'd1, 8'hFD);
    chk("bp_hold_md", obs_d[0], 64'h0000_0000_0000_2100);
    step(1, 8'h22, 1, 3'd1, 8'hFF);
    chk("bp_rel_md", obs_d[0], 64'h0000_0000_0000_2200);
    chk("bp_rel_ml", 64'(obs_l[0]), 64'h02);
    step(0, 8'h00, 0, 3'd0, 8'hFF);

    // back-to-back packets ch0 then ch7
    step(1, 8'hA0, 0, 3'd0, 8'hFF);
    step(1, 8'hA1, 1, 3'd0, 8'hFF);
    step(1, 8'hB0, 0, 3'd7, 8'hFF);
    step(1, 8'hB1, 1, 3'd7, 8'hFF);
    chk("b2b_mv", 64'(obs_v[0]), 64'h80);
    step(0, 8'h00, 0, 3'd0, 8'hFF);

    // reset during beat 2 of a ch0 packet
    step(1, 8'h30, 0, 3'd0, 8'hFF);
    tb_valid = 1; tb_data = 8'h31; tb_last = 0; tb_sel = 3'd0;
    do_reset();
    step(1, 8'h44, 1, 3'd4, 8'hFF);
    chk("post_rst_mv", 64'(obs_v[0]), 64'h10);
    chk("post_rst_md", obs_d[0], 64'h0000_0044_0000_0000);
    step(0, 8'h00, 0, 3'd0, 8'hFF);

    // out-of-range select on the 6-channel instance
    step(1, 8'h50, 0, 3'd7, 8'hFF);
    step(1, 8'h51, 0, 3'd0, 8'hFF);
    step(1, 8'h52, 1, 3'd0, 8'hFF);
    chk("drop_cnt1", 64'(obs_cnt[1]), 64'd1);
    chk("drop_mv", 64'(obs_v[1]), 64'h00);
    for (int p = 0; p < 255; p++) begin
      step(1, 8'(p), 0, 3'd7, 8'hFF);
      step(1, 8'(p), 0, 3'd6, 8'hFF);
      step(1, 8'(p), 1, 3'd1, 8'hFF);
    end
    chk("drop_sat", 64'(obs_cnt[1]), 64'd255);
    step(1, 8'h60, 1, 3'd6, 8'hFF);
    chk("drop_sat_hold", 64'(obs_cnt[1]), 64'd255);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) == 0,
           3'($urandom_range(0, 7)), 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
